// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
`ifndef XLEN
`define XLEN 32
`endif

package seq_divider_pkg;

    // RISC-V M-extension divide/remainder flavours; encoding matches the op port.
    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    // Wide enough to count N-1 down to 0.
    localparam int DIV_CNT_W = $clog2(`XLEN);

    function automatic logic op_is_signed(input div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/AdderNZCV.sv
// Ripple-style N-bit adder/subtractor with NZCV flags.
// control=1 computes a - b as a + ~b + 1; c=1 then means "no borrow".
module AdderNZCV #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         control,
    output logic [N-1:0] s,
    output logic         n,
    output logic         z,
    output logic         c,
    output logic         v
);

    logic [N-1:0] b_eff;

    assign b_eff  = b ^ {N{control}};
    assign {c, s} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, control};
    assign n      = s[N-1];
    assign z      = (s == '0);
    assign v      = (a[N-1] == b_eff[N-1]) && (s[N-1] != a[N-1]);

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per
// cycle through a single shared N+1-bit subtractor, plus one fixed fix-up
// cycle that reuses the same subtractor to negate signed results.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = `XLEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    input  logic         kill,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         busy
);

    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    div_state_t           state;
    div_op_t              cur_op;
    logic [DIV_CNT_W-1:0] counter;
    logic [N-1:0]         quo;
    logic [N-1:0]         rem;
    logic [N-1:0]         dvsr;
    logic                 neg_q;
    logic                 neg_r;

    // Shared subtractor ports.
    logic [N:0]           adder_a;
    logic [N:0]           adder_b;
    logic                 adder_ctl;
    logic [N:0]           adder_sum;
    logic                 adder_c;
    logic                 flag_n_unused;
    logic                 flag_z_unused;
    logic                 flag_v_unused;
    logic                 sum_msb_unused;

    // Request decode on the raw inputs, used only in IDLE.
    div_op_t              in_op;
    logic                 in_signed;
    logic                 in_rem;
    logic                 in_div_zero;
    logic                 in_overflow;

    // Fix-up operand selection.
    logic [N-1:0]         fix_val;
    logic                 fix_neg;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    assign in_op       = div_op_t'(op);
    assign in_signed   = op_is_signed(in_op);
    assign in_rem      = op_is_rem(in_op);
    assign in_div_zero = (divisor == '0);
    assign in_overflow = in_signed && (dividend == MOST_NEG) && (divisor == '1);

    assign fix_val = op_is_rem(cur_op) ? rem : quo;
    assign fix_neg = op_is_rem(cur_op) ? neg_r : neg_q;

    // Trial remainder never exceeds the divisor, so the sum MSB carries no information.
    assign sum_msb_unused = adder_sum[N];

    // Magnitude of a signed operand; the most-negative value maps to 2^(N-1), which fits.
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] x, input logic is_signed);
        return (is_signed && x[N-1]) ? (~x + 1'b1) : x;
    endfunction

    AdderNZCV #(.N(N + 1)) u_adder (
        .a       (adder_a),
        .b       (adder_b),
        .control (adder_ctl),
        .s       (adder_sum),
        .n       (flag_n_unused),
        .z       (flag_z_unused),
        .c       (adder_c),
        .v       (flag_v_unused)
    );

    // Steer the shared subtractor: trial subtract in ITER, 0 - X in FIXUP, idle otherwise.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        adder_a   = '0;
        adder_b   = '0;
        adder_ctl = 1'b0;
        case (state)
            ITER: begin
                adder_a   = {rem, quo[N-1]};
                adder_b   = {1'b0, dvsr};
                adder_ctl = 1'b1;
            end
            FIXUP: begin
                adder_a   = '0;
                adder_b   = {1'b0, fix_val};
                adder_ctl = 1'b1;
            end
            default: ;
        endcase
    end

    // Control FSM and datapath registers; kill beats every other transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, so nothing stale is ever observable on result.
            state   <= IDLE;
            cur_op  <= DIV;
            counter <= '0;
            quo     <= '0;
            rem     <= '0;
            dvsr    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            result  <= '0;
        end else if (kill && (state != IDLE)) begin
            // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cur_op <= in_op;
                        if (in_div_zero) begin
                            result <= in_rem ? dividend : '1;
                            state  <= DONE;
                        end else if (in_overflow) begin
                            result <= in_rem ? '0 : dividend;
                            state  <= DONE;
                        end else begin
                            quo     <= magnitude(dividend, in_signed);
                            dvsr    <= magnitude(divisor, in_signed);
                            rem     <= '0;
                            neg_q   <= in_signed && (dividend[N-1] ^ divisor[N-1]);
                            neg_r   <= in_signed && dividend[N-1];
                            counter <= DIV_CNT_W'(N - 1);
                            state   <= ITER;
                        end
                    end
                end
                ITER: begin
                    if (adder_c) begin
                        rem <= adder_sum[N-1:0];
                    end else begin
                        rem <= {rem[N-2:0], quo[N-1]};
                    end
                    quo <= {quo[N-2:0], adder_c};
                    if (counter == '0) begin
                        state <= FIXUP;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                FIXUP: begin
                    result <= fix_neg ? adder_sum[N-1:0] : fix_val;
                    state  <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, hand-written
// handshake/kill/reset sequences, and a randomized sweep against an
// arithmetic reference model of RISC-V DIV/DIVU/REM/REMU.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int N          = 32;
    localparam int NORMAL_LAT = N + 2;
    localparam int TIMEOUT    = 200;
    localparam int RAND_OPS   = 1000;
    localparam logic [N-1:0] MOST_NEG = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         kill;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        div_op_t      op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Architectural result from plain 64-bit arithmetic; truncating division
    // matches RISC-V, and the overflow case falls out of the low 32 bits.
    function automatic logic [N-1:0] ref_div(input div_op_t o, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        bit     sgn;
        bit     want_rem;
        sgn      = (o == DIV) || (o == REM);
        want_rem = (o == REM) || (o == REMU);
        if (b == '0) return want_rem ? a : '1;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        q  = sa / sb;
        r  = sa % sb;
        return want_rem ? r[N-1:0] : q[N-1:0];
    endfunction

    function automatic int ref_lat(input div_op_t o, input logic [N-1:0] a, input logic [N-1:0] b);
        bit sgn;
        sgn = (o == DIV) || (o == REM);
        if (b == '0) return 1;
        if (sgn && a == MOST_NEG && b == '1) return 1;
        return NORMAL_LAT;
    endfunction

    function automatic logic [N-1:0] pick_operand();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return '0;
        if (sel == 1) return 32'd1;
        if (sel == 2) return '1;
        if (sel == 3) return MOST_NEG;
        if (sel == 4) return 32'h7FFF_FFFF;
        if (sel == 5) return N'($urandom_range(0, 15));
        return N'($urandom());
    endfunction

    // Issue one request, measure cycles from the accept edge to out_valid, then consume it.
    task automatic do_op(input div_op_t o, input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit kill_too, output logic [N-1:0] res, output int lat);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_wait", N'(in_ready), N'(1));
            res = 'x;
            lat = -1;
            return;
        end
        in_valid = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        kill     = kill_too;
        @(negedge clk);
        in_valid = 1'b0;
        kill     = 1'b0;
        lat      = 1;
        while (!out_valid && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("out_valid_wait", N'(out_valid), N'(1));
        res       = result;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic wait_out_valid(input string name);
        int waited;
        waited = 0;
        while (!out_valid && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        if (!out_valid) check(name, N'(out_valid), N'(1));
    endtask

    initial begin
        logic [N-1:0] res;
        logic [N-1:0] a;
        logic [N-1:0] b;
        div_op_t      o;
        int           lat;
        bit           seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        kill      = 1'b0;
        out_ready = 1'b0;
        op        = 2'd0;
        dividend  = '0;
        divisor   = '0;

        // Reset state.
        #12;
        check("reset_in_ready", N'(in_ready), N'(1));
        check("reset_busy", N'(busy), N'(0));
        check("reset_out_valid", N'(out_valid), N'(0));
        check("reset_result", result, '0);
        #5 rst_n = 1'b1;

        // Directed vectors: {op, dividend, divisor, expected result, expected latency}.
        vecs.push_back('{DIVU, 32'd100,       32'd7,        32'd14,        NORMAL_LAT});
        vecs.push_back('{REMU, 32'd100,       32'd7,        32'd2,         NORMAL_LAT});
        vecs.push_back('{DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, NORMAL_LAT});
        vecs.push_back('{REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, NORMAL_LAT});
        vecs.push_back('{DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, NORMAL_LAT});
        vecs.push_back('{REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         NORMAL_LAT});
        vecs.push_back('{DIVU, 32'd5,         32'd0,        32'hFFFF_FFFF, 1});
        vecs.push_back('{REM,  32'd5,         32'd0,        32'd5,         1});
        vecs.push_back('{DIV,  32'd5,         32'd0,        32'hFFFF_FFFF, 1});
        vecs.push_back('{DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
        vecs.push_back('{DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         NORMAL_LAT});
        vecs.push_back('{DIV,  32'h8000_0000, 32'd1,        32'h8000_0000, NORMAL_LAT});
        vecs.push_back('{REM,  32'h8000_0000, 32'd3,        32'hFFFF_FFFE, NORMAL_LAT});
        vecs.push_back('{REMU, 32'd0,         32'd3,        32'd0,         NORMAL_LAT});

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), N'(lat), N'(vecs[i].lat));
        end

        // Backpressure: result and out_valid hold while out_ready is low.
        @(negedge clk);
        in_valid = 1'b1;
        op       = DIVU;
        dividend = 32'd1000;
        divisor  = 32'd10;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid("bp_out_valid_wait");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_out_valid", i), N'(out_valid), N'(1));
            check($sformatf("bp%0d_result", i), result, 32'd100);
            check($sformatf("bp%0d_in_ready", i), N'(in_ready), N'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_in_ready", N'(in_ready), N'(1));
        check("bp_release_out_valid", N'(out_valid), N'(0));
        in_valid = 1'b1;
        op       = DIVU;
        dividend = 32'd9;
        divisor  = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_accepted", N'(busy), N'(1));
        wait_out_valid("bp_next_wait");
        check("bp_next_result", result, 32'd3);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Kill during the 10th ITER cycle: back to IDLE, no result delivered.
        in_valid = 1'b1;
        op       = DIVU;
        dividend = 32'hFFFF_FFFF;
        divisor  = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("kill_busy_before", N'(busy), N'(1));
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy_after", N'(busy), N'(0));
        check("kill_out_valid_after", N'(out_valid), N'(0));
        check("kill_in_ready_after", N'(in_ready), N'(1));
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("kill_no_result", N'(seen), N'(0));
        do_op(DIVU, 32'hFFFF_FFFF, 32'd1, 1'b0, res, lat);
        check("post_kill_result", res, 32'hFFFF_FFFF);
        check("post_kill_latency", N'(lat), N'(NORMAL_LAT));

        // Kill together with a request in IDLE is ignored; the request runs normally.
        do_op(DIV, 32'hFFFF_FF9C, 32'd7, 1'b1, res, lat);
        check("idle_kill_result", res, 32'hFFFF_FFF2);
        check("idle_kill_latency", N'(lat), N'(NORMAL_LAT));

        // Asynchronous reset pulse in the middle of ITER, away from any clock edge.
        in_valid = 1'b1;
        op       = DIV;
        dividend = 32'd12345;
        divisor  = 32'hFFFF_FFEF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_busy", N'(busy), N'(0));
        check("areset_out_valid", N'(out_valid), N'(0));
        check("areset_in_ready", N'(in_ready), N'(1));
        check("areset_result", result, '0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("areset_release_in_ready", N'(in_ready), N'(1));
        check("areset_release_busy", N'(busy), N'(0));
        do_op(DIV, 32'd12345, 32'hFFFF_FFEF, 1'b0, res, lat);
        check("post_reset_result", res, ref_div(DIV, 32'd12345, 32'hFFFF_FFEF));

        // Randomized sweep over all four ops with corner-heavy operands.
        for (int i = 0; i < RAND_OPS; i++) begin
            o = div_op_t'($urandom_range(0, 3));
            a = pick_operand();
            b = pick_operand();
            do_op(o, a, b, 1'b0, res, lat);
            check($sformatf("rand%0d_%s_%08h_%08h", i, o.name(), a, b), res, ref_div(o, a, b));
            check($sformatf("rand%0d_latency", i), N'(lat), N'(ref_lat(o, a, b)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
